// File: rtl/data_island_packet_serializer_if.sv
// rtl/data_island_packet_serializer_if.sv - packet in / TERC4 nibble stream out bundle for the data-island serializer
interface data_island_packet_serializer_if;
    logic        data_island_period;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic        load;
    logic [4:0]  counter;
    logic [8:0]  packet_data;

    modport master (
        output data_island_period,
        output header,
        output sub,
        input  load,
        input  counter,
        input  packet_data
    );

    modport slave (
        input  data_island_period,
        input  header,
        input  sub,
        output load,
        output counter,
        output packet_data
    );
endinterface

// File: rtl/data_island_packet_serializer.sv
// rtl/data_island_packet_serializer.sv - HDMI data-island packet serializer with BCH ECC generation
module data_island_packet_serializer #(
    parameter logic [7:0] ECC_FEEDBACK = 8'b1000_0011
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset,
    data_island_packet_serializer_if.slave       bus
);
    logic [4:0]  counter;
    logic [8:0]  packet_data;
    logic [8:0]  packet_data_next;
    logic [23:0] header_q;
    logic [55:0] sub_q [3:0];
    logic [7:0]  ecc_h;
    logic [7:0]  ecc_s [3:0];
    logic        load;

    logic [23:0] cur_header;
    logic [55:0] cur_sub [3:0];
    logic [7:0]  ecc_h_base;
    logic [7:0]  ecc_h_next;
    logic [7:0]  ecc_s_base [3:0];
    logic [7:0]  ecc_s_next [3:0];
    logic        hdr_phase;
    logic        sub_phase;
    logic [5:0]  bit_lo;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? ECC_FEEDBACK : 8'h00);
    endfunction

    assign load            = bus.data_island_period && (counter == 5'd0);
    assign bus.load        = load;
    assign bus.counter     = counter;
    assign bus.packet_data = packet_data;

    // At the load edge the live inputs stand in for the shadows and the ECC starts from zero.
    always_comb begin
        hdr_phase        = (counter < 5'd24);
        sub_phase        = (counter < 5'd28);
        bit_lo           = {counter, 1'b0};
        cur_header       = load ? bus.header : header_q;
        ecc_h_base       = load ? 8'h00 : ecc_h;
        ecc_h_next       = ecc_h_base;
        packet_data_next = '0;

        if (hdr_phase) begin
            packet_data_next[0] = cur_header[counter];
            ecc_h_next          = ecc_step(ecc_h_base, cur_header[counter]);
        end else begin
            packet_data_next[0] = ecc_h[counter[2:0]];
        end

        for (int i = 0; i < 4; i++) begin
            cur_sub[i]    = load ? bus.sub[i] : sub_q[i];
            ecc_s_base[i] = load ? 8'h00 : ecc_s[i];
            ecc_s_next[i] = ecc_s_base[i];
            if (sub_phase) begin
                packet_data_next[1 + i] = cur_sub[i][bit_lo];
                packet_data_next[5 + i] = cur_sub[i][bit_lo + 6'd1];
                ecc_s_next[i] = ecc_step(ecc_step(ecc_s_base[i], cur_sub[i][bit_lo]),
                                         cur_sub[i][bit_lo + 6'd1]);
            end else begin
                packet_data_next[1 + i] = ecc_s[i][{counter[1:0], 1'b0}];
                packet_data_next[5 + i] = ecc_s[i][{counter[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            counter     <= 5'd0;
            packet_data <= 9'd0;
            ecc_h       <= 8'h00;
            header_q    <= 24'd0;
            for (int i = 0; i < 4; i++) begin
                ecc_s[i] <= 8'h00;
                sub_q[i] <= 56'd0;
            end
        end else if (!bus.data_island_period) begin
            counter     <= 5'd0;
            packet_data <= 9'd0;
            ecc_h       <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                ecc_s[i] <= 8'h00;
            end
        end else begin
            counter     <= counter + 5'd1;
            packet_data <= packet_data_next;
            ecc_h       <= ecc_h_next;
            for (int i = 0; i < 4; i++) begin
                ecc_s[i] <= ecc_s_next[i];
            end
            if (load) begin
                header_q <= bus.header;
                for (int i = 0; i < 4; i++) begin
                    sub_q[i] <= bus.sub[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_island_packet_serializer.sv
// tb/tb_data_island_packet_serializer.sv - scoreboard bench for the data-island packet serializer
module tb_data_island_packet_serializer;
    logic clk_pixel = 1'b0;
    logic reset;

    data_island_packet_serializer_if bus ();

    data_island_packet_serializer dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int         checks = 0;
    int         errors = 0;
    int         mcount = 0;
    logic [8:0] sb [$];
    logic [8:0] exp_words [32];

    // Feedback taps of x^8+x^7+x^6+1 written out bit by bit.
    function automatic logic [7:0] ref_step(input logic [7:0] e, input logic b);
        logic fb;
        fb = e[0] ^ b;
        return {fb, e[7:3], e[2] ^ fb, e[1] ^ fb};
    endfunction

    task automatic model_load();
        logic [7:0] eh;
        logic [7:0] es [4];
        eh = 8'h00;
        for (int k = 0; k < 24; k++) eh = ref_step(eh, bus.header[k]);
        for (int i = 0; i < 4; i++) begin
            es[i] = 8'h00;
            for (int b = 0; b < 56; b++) es[i] = ref_step(es[i], bus.sub[i][b]);
        end
        for (int k = 0; k < 32; k++) begin
            exp_words[k] = '0;
            exp_words[k][0] = (k < 24) ? bus.header[k] : eh[k - 24];
            for (int i = 0; i < 4; i++) begin
                if (k < 28) begin
                    exp_words[k][1 + i] = bus.sub[i][2 * k];
                    exp_words[k][5 + i] = bus.sub[i][2 * k + 1];
                end else begin
                    exp_words[k][1 + i] = es[i][2 * (k - 28)];
                    exp_words[k][5 + i] = es[i][2 * (k - 28) + 1];
                end
            end
        end
    endtask

    task automatic tick(input logic dip);
        bus.data_island_period = dip;
        if (dip) begin
            if (mcount == 0) model_load();
            sb.push_back(exp_words[mcount]);
            mcount = (mcount + 1) % 32;
        end else begin
            sb.push_back(9'd0);
            mcount = 0;
        end
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic set_packet(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                              input logic [55:0] s2, input logic [55:0] s3);
        bus.header = h;
        bus.sub[0] = s0;
        bus.sub[1] = s1;
        bus.sub[2] = s2;
        bus.sub[3] = s3;
    endtask

    task automatic randomize_inputs();
        logic [63:0] r;
        bus.header = 24'($urandom());
        for (int i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()};
            bus.sub[i] = r[55:0];
        end
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        reset = 1'b1;
        bus.data_island_period = 1'b0;
        set_packet(24'd0, 56'd0, 56'd0, 56'd0, 56'd0);
        repeat (2) @(posedge clk_pixel);
        #1;
        checks++;
        if (bus.counter !== 5'd0) begin
            errors++;
            $display("FAIL reset_counter got %0d exp 0", bus.counter);
        end
        checks++;
        if (bus.packet_data !== 9'd0) begin
            errors++;
            $display("FAIL reset_packet_data got %h exp 000", bus.packet_data);
        end
        checks++;
        if (bus.load !== 1'b0) begin
            errors++;
            $display("FAIL reset_load got %b exp 0", bus.load);
        end
        reset = 1'b0;
        mcount = 0;
        sb.delete();
        exp = 9'd0;
    endtask

    task automatic test_all_zero();
        logic [8:0] exp;
        set_packet(24'd0, 56'd0, 56'd0, 56'd0, 56'd0);
        for (int c = 0; c < 32; c++) begin
            bus.data_island_period = 1'b1;
            #1;
            checks++;
            if (bus.load !== (c == 0)) begin
                errors++;
                $display("FAIL zero_load cycle %0d got %b exp %b", c, bus.load, (c == 0));
            end
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp || exp !== 9'd0) begin
                errors++;
                $display("FAIL zero_data pixel %0d got %h exp 000", c, bus.packet_data);
            end
        end
    endtask

    task automatic test_header_ecc();
        logic [8:0] exp;
        logic [7:0] ecc_seen;
        set_packet(24'h000001, 56'd0, 56'd0, 56'd0, 56'd0);
        ecc_seen = 8'h00;
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp) begin
                errors++;
                $display("FAIL header_data pixel %0d got %h exp %h", c, bus.packet_data, exp);
            end
            if (c >= 24) ecc_seen[c - 24] = bus.packet_data[0];
        end
        checks++;
        if (ecc_seen !== 8'h4A) begin
            errors++;
            $display("FAIL header_ecc_byte got %h exp 4a", ecc_seen);
        end
    endtask

    task automatic test_subpackets();
        logic [8:0]  exp;
        logic [55:0] one;
        one = 56'd1;
        for (int i = 0; i < 4; i++) begin
            set_packet(24'd0, (i == 0) ? one : 56'd0, (i == 1) ? one : 56'd0,
                       (i == 2) ? one : 56'd0, (i == 3) ? one : 56'd0);
            for (int c = 0; c < 32; c++) begin
                tick(1'b1);
                exp = sb.pop_front();
                checks++;
                if (bus.packet_data !== exp) begin
                    errors++;
                    $display("FAIL sub%0d_data pixel %0d got %h exp %h", i, c, bus.packet_data, exp);
                end
                if (c == 0) begin
                    checks++;
                    if (bus.packet_data !== (9'd1 << (1 + i))) begin
                        errors++;
                        $display("FAIL sub%0d_pixel0 got %h exp %h", i, bus.packet_data, 9'd1 << (1 + i));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        for (int p = 0; p < 64; p++) begin
            for (int c = 0; c < 32; c++) begin
                randomize_inputs();
                tick(1'b1);
                exp = sb.pop_front();
                checks++;
                if (bus.packet_data !== exp) begin
                    errors++;
                    $display("FAIL b2b_data packet %0d pixel %0d got %h exp %h", p, c, bus.packet_data, exp);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [8:0] exp;
        randomize_inputs();
        for (int c = 0; c < 13; c++) begin
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp) begin
                errors++;
                $display("FAIL drop_pre pixel %0d got %h exp %h", c, bus.packet_data, exp);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp || bus.counter !== 5'd0) begin
                errors++;
                $display("FAIL drop_idle cycle %0d got %h/%0d exp %h/0", c, bus.packet_data, bus.counter, exp);
            end
        end
        randomize_inputs();
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp) begin
                errors++;
                $display("FAIL drop_restart pixel %0d got %h exp %h", c, bus.packet_data, exp);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [8:0] exp;
        randomize_inputs();
        for (int c = 0; c < 20; c++) begin
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp) begin
                errors++;
                $display("FAIL rst_pre pixel %0d got %h exp %h", c, bus.packet_data, exp);
            end
        end
        checks++;
        if (bus.counter !== 5'd20) begin
            errors++;
            $display("FAIL rst_counter_before got %0d exp 20", bus.counter);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.counter !== 5'd0 || bus.packet_data !== 9'd0) begin
            errors++;
            $display("FAIL rst_async got %0d/%h exp 0/000", bus.counter, bus.packet_data);
        end
        sb.delete();
        mcount = 0;
        bus.data_island_period = 1'b0;
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        randomize_inputs();
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            exp = sb.pop_front();
            checks++;
            if (bus.packet_data !== exp) begin
                errors++;
                $display("FAIL rst_after pixel %0d got %h exp %h", c, bus.packet_data, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_header_ecc();
        test_subpackets();
        test_back_to_back();
        test_drop();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
